irq_controller: RTL and testbench

//  Memory-mapped interrupt controller feeding the single-cycle CPU's IRQ input.

---
 rtl/irqc_pkg.sv | 26 ++
 rtl/irqc_prio_enc.sv | 24 ++
 rtl/irq_controller.sv | 178 +++++++++++++++++
 tb/tb_irq_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irqc_pkg.sv
// Shared constants for the interrupt controller: register offsets,
// FSM state encodings, ID width and control bit positions.
package irqc_pkg;

  localparam int ID_W = 5;

  // Byte offsets inside the 32-byte register window
  localparam logic [4:0] OFF_MASK = 5'h00;
  localparam logic [4:0] OFF_PEND = 5'h04;
  localparam logic [4:0] OFF_ID   = 5'h08;
  localparam logic [4:0] OFF_CTRL = 5'h0C;
  localparam logic [4:0] OFF_TH   = 5'h10;
  localparam logic [4:0] OFF_TL   = 5'h14;
  localparam logic [4:0] OFF_TCON = 5'h18;

  // Control bit positions
  localparam int CTRL_GEN_BIT = 0;
  localparam int TCON_EN_BIT  = 0;
  localparam int ID_VALID_BIT = 31;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/irqc_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins, reports {any, index}.
module irqc_prio_enc
  import irqc_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] vec_i,
  output logic             any_o,
  output logic [ID_W-1:0]  idx_o
);

  // Scan high to low so the last hit (lowest index) takes the result
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        any_o = 1'b1;
        idx_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller for the single-cycle CPU.
// Edge-latched sources, mask, global enable, one-at-a-time sequencing
// IDLE -> REQ -> SERVICE -> IDLE. Optional internal timer is built when
// the macro IRQC_TIMER_EN is defined; otherwise its registers read 0.
module irq_controller
  import irqc_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             irq_ack,
  input  logic             irq_ret,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             cpu_irq,
  output logic [ID_W-1:0]  irq_id
);

  logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q, rise;
  logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d;
  logic [N_SRC-1:0] set_v, w1c_v, ack_clr;
  logic             ctrl_en_q, ctrl_en_d;
  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             cpu_irq_q;
  logic             enc_any;
  logic [ID_W-1:0]  enc_idx;
  logic             in_win, wr_en;
  logic [4:0]       off;
  logic             timer_fire;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  assign in_win = (addr[31:5] == BASE_ADDR[31:5]);
  assign off    = addr[4:0];
  assign wr_en  = wr && in_win;

  // Two-flop synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  irqc_prio_enc #(.N_SRC(N_SRC)) u_enc (
    .vec_i (pend_q & mask_q),
    .any_o (enc_any),
    .idx_o (enc_idx)
  );

`ifdef IRQC_TIMER_EN
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic        tcon_en_q, tcon_en_d;

  assign timer_fire = tcon_en_q && (tl_q == 32'hFFFF_FFFF);

  // Timer next state: a bus write to TL overrides counting/reload
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_en_d = tcon_en_q;
    if (tcon_en_q) tl_d = timer_fire ? th_q : tl_q + 32'd1;
    if (wr_en && off == OFF_TH)   th_d      = wdata;
    if (wr_en && off == OFF_TL)   tl_d      = wdata;
    if (wr_en && off == OFF_TCON) tcon_en_d = wdata[TCON_EN_BIT];
  end

  // Timer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_en_q <= 1'b0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_en_q <= tcon_en_d;
    end
  end
`else
  assign timer_fire = 1'b0;
`endif

  // Sequencer: withdrawal is checked before ack so a stale ack never
  // services an empty request
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_clr = '0;
    case (state_q)
      ST_IDLE: if (ctrl_en_q && enc_any) state_d = ST_REQ;
      ST_REQ: begin
        if (!ctrl_en_q || !enc_any) begin
          state_d = ST_IDLE;
        end else if (irq_ack) begin
          state_d = ST_SERVICE;
          id_d    = enc_idx;
          ack_clr = N_SRC'(1) << enc_idx;
        end
      end
      ST_SERVICE: if (irq_ret) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus writes and pending update; a new edge beats W1C or ack-clear
  always_comb begin
    mask_d    = mask_q;
    ctrl_en_d = ctrl_en_q;
    w1c_v     = '0;
    set_v     = rise;
    set_v[0]  = rise[0] | timer_fire;
    if (wr_en && off == OFF_MASK) mask_d    = wdata[N_SRC-1:0];
    if (wr_en && off == OFF_CTRL) ctrl_en_d = wdata[CTRL_GEN_BIT];
    if (wr_en && off == OFF_PEND) w1c_v     = wdata[N_SRC-1:0];
    pend_d = (pend_q & ~w1c_v & ~ack_clr) | set_v;
  end

  // Controller state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      pend_q    <= '0;
      ctrl_en_q <= 1'b0;
      state_q   <= ST_IDLE;
      id_q      <= '0;
      cpu_irq_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      ctrl_en_q <= ctrl_en_d;
      state_q   <= state_d;
      id_q      <= id_d;
      cpu_irq_q <= (state_d == ST_REQ);
    end
  end

  assign cpu_irq = cpu_irq_q;
  assign irq_id  = id_q;

  // Combinational read mux; zero outside the window or without rd
  always_comb begin
    rdata = '0;
    if (rd && in_win) begin
      case (off)
        OFF_MASK: rdata = 32'(mask_q);
        OFF_PEND: rdata = 32'(pend_q);
        OFF_ID: begin
          rdata               = 32'(id_q);
          rdata[ID_VALID_BIT] = (state_q == ST_SERVICE);
        end
        OFF_CTRL: rdata = {31'd0, ctrl_en_q};
`ifdef IRQC_TIMER_EN
        OFF_TH:   rdata = th_q;
        OFF_TL:   rdata = tl_q;
        OFF_TCON: rdata = {31'd0, tcon_en_q};
`endif
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: each task pushes expected values to a
// scoreboard queue as stimulus is driven and pops them when the DUT output
// is sampled (one time unit after the active edge).
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_MASK = BASE + 32'h00, A_PEND = BASE + 32'h04;
  localparam logic [31:0] A_ID   = BASE + 32'h08, A_CTRL = BASE + 32'h0C;
  localparam logic [31:0] A_TH   = BASE + 32'h10, A_TL   = BASE + 32'h14;
  localparam logic [31:0] A_TCON = BASE + 32'h18;

  logic        clk, reset, irq_ack, irq_ret, rd, wr, cpu_irq;
  logic [7:0]  src;
  logic [31:0] addr, wdata, rdata;
  logic [4:0]  irq_id;

  logic [31:0] exp_q[$];
  logic [31:0] exp, got;
  int n_tests = 0, n_fail = 0;

  irq_controller #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .irq_ack(irq_ack), .irq_ret(irq_ret),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .cpu_irq(cpu_irq), .irq_id(irq_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    rd = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 12 && cpu_irq !== 1'b1; i++) tick();
  endtask

  task automatic src_idle();
    src = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); got = 32'(cpu_irq);
    if (got !== exp) begin $display("FAIL rst_cpu_irq got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    exp = exp_q.pop_front(); got = 32'(irq_id);
    if (got !== exp) begin $display("FAIL rst_irq_id got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_MASK, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rst_mask got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rst_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_CTRL, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rst_ctrl got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
  endtask

  task automatic test_basic();
    bus_wr(A_MASK, 32'hFF);
    bus_wr(A_CTRL, 32'h1);
    bus_rd(A_MASK, got); exp = 32'hFF;
    if (got !== exp) begin $display("FAIL mask_rw got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    src = 8'h20;                                   // rises before edge k
    exp_q.push_back(32'h00); exp_q.push_back(32'h20);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h1);
    tick(); tick();                                // k, k+1
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL pend_k1 got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick();                                        // k+2
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL pend_k2 got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL irq_k2 got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick();                                        // k+3
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL irq_k3 got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    exp_q.push_back(32'd5); exp_q.push_back(32'h0);
    exp_q.push_back(32'h8000_0005); exp_q.push_back(32'h0);
    pulse_ack();
    got = 32'(irq_id); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL basic_id got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL basic_pend_clr got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_ID, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL basic_idreg got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL basic_irq_svc got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    exp_q.push_back(32'h0); exp_q.push_back(32'h5);
    pulse_ret(); tick();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL basic_irq_ret got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_ID, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL basic_id_held got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    src_idle();
  endtask

  task automatic test_priority();
    src = 8'h44;
    exp_q.push_back(32'd2); exp_q.push_back(32'h40);
    exp_q.push_back(32'h1); exp_q.push_back(32'd6);
    wait_irq();
    pulse_ack();
    got = 32'(irq_id); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL prio_first got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL prio_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    pulse_ret(); tick();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL prio_reassert got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    pulse_ack();
    got = 32'(irq_id); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL prio_second got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    pulse_ret();
    src_idle();
  endtask

  task automatic test_withdraw();
    src = 8'h02;
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    wait_irq();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL wd_irq_up got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_wr(A_PEND, 32'h02);
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL wd_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL wd_irq_down got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    pulse_ack();                                   // ignored outside REQ
    bus_rd(A_ID, got); exp = exp_q.pop_front();
    if (got[31] !== exp[0]) begin $display("FAIL wd_no_service got=%h exp=%h", got[31], exp[0]); n_fail++; end
    n_tests++;
    src_idle();
  endtask

  task automatic test_no_nesting();
    src = 8'h10;
    exp_q.push_back(32'd4); exp_q.push_back(32'h01);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    wait_irq();
    pulse_ack();
    got = 32'(irq_id); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL nest_id got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    src = 8'h11;
    repeat (4) tick();
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL nest_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL nest_irq_held got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    pulse_ret();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL nest_irq_ret got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL nest_irq_after got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    pulse_ack(); pulse_ret();
    src_idle();
  endtask

  task automatic test_set_wins();
    bus_wr(A_MASK, 32'h7F);                        // keep src[7] masked
    src = 8'h80;
    exp_q.push_back(32'h80); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    tick(); tick();                                // k, k+1
    bus_wr(A_PEND, 32'h80);                        // W1C lands on k+2 with the set
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL setwins_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick(); tick();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL setwins_masked got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_wr(A_PEND, 32'h80);
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL w1c_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_wr(A_MASK, 32'hFF);
    src_idle();
  endtask

  task automatic test_bus_window();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_rd(BASE + 32'h20, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL win_outside got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    addr = A_MASK; #1 got = rdata;                 // rd low
    exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL win_no_rd got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(BASE + 32'h1C, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL win_unmapped got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
  endtask

  task automatic test_reset_mid_service();
    src = 8'h08;
    exp_q.push_back(32'd3); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    wait_irq();
    pulse_ack();
    got = 32'(irq_id); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rms_id got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    src = 8'h00;
    reset = 1'b1; #1;
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rms_irq got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    got = 32'(irq_id); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rms_irq_id got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick();
    bus_rd(A_ID, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rms_idreg got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rms_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    reset = 1'b0;
    tick();
    bus_rd(A_MASK, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL rms_mask got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
  endtask

`ifdef IRQC_TIMER_EN
  task automatic test_timer();
    bus_wr(A_MASK, 32'h1);
    bus_wr(A_CTRL, 32'h1);
    bus_wr(A_TH, 32'hFFFF_FFFC);
    bus_wr(A_TL, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
    exp_q.push_back(32'h1); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    bus_wr(A_TCON, 32'h1);
    repeat (3) tick();
    bus_rd(A_TL, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL tmr_tl_max got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL tmr_pend_early got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick();
    bus_rd(A_PEND, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL tmr_pend got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_rd(A_TL, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL tmr_reload got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL tmr_irq_early got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    tick();
    got = 32'(cpu_irq); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL tmr_irq got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    bus_wr(A_TCON, 32'h0);
    pulse_ack(); pulse_ret();
  endtask
`else
  task automatic test_timer_absent();
    bus_wr(A_TH, 32'h1234_5678);
    bus_wr(A_TCON, 32'h1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_rd(A_TH, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL notmr_th got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
    repeat (3) tick();
    bus_rd(A_TCON, got); exp = exp_q.pop_front();
    if (got !== exp) begin $display("FAIL notmr_tcon got=%h exp=%h", got, exp); n_fail++; end
    n_tests++;
  endtask
`endif

  initial begin
    reset = 1'b1; src = '0; irq_ack = 1'b0; irq_ret = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_basic();
    test_priority();
    test_withdraw();
    test_no_nesting();
    test_set_wins();
    test_bus_window();
    test_reset_mid_service();
`ifdef IRQC_TIMER_EN
    test_timer();
`else
    test_timer_absent();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
